// File: rtl/imm_encoder_pkg.sv
// Shared types and helpers for the RISC-V immediate encoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: format codes, error-bit positions, the stage-2 item struct and
// the signed-fit helper used by the range checks.
package imm_pkg;

   // Format code carried on in_fmt; codes 3'b101..3'b111 are illegal.
   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_fmt_e;

   // Bit positions inside the 3-bit error vector.
   localparam int ERR_RANGE = 0;
   localparam int ERR_ALIGN = 1;
   localparam int ERR_FMT   = 2;

   // Tag width held in the item struct. The top-level TAG_W must not exceed
   // this; raise it here if a wider tag is ever needed.
   localparam int ENC_TAG_W = 4;

   typedef struct packed {
      logic [31:0]          instr;
      logic [2:0]           err;
      logic [ENC_TAG_W-1:0] tag;
   } enc_item_t;

   // True when v is a sign-extension of its low w bits, i.e. bits
   // [31:w-1] are all equal.
   function automatic logic fits_signed(input logic [31:0] v, input int unsigned w);
      logic [31:0] hi_mask;
      hi_mask = 32'hFFFF_FFFF << (w - 1);
      return ((v & hi_mask) == 32'h0) || ((v & hi_mask) == hi_mask);
   endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational immediate packer: checks an immediate and patches it into an instruction.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated on whatever stage 1 currently holds.
// Ports: fmt/imm/instr_in in; instr_out = patched word, err = {fmt, align, range}.
module imm_pack
   import imm_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [31:0] imm,
   input  logic [31:0] instr_in,
   output logic [31:0] instr_out,
   output logic [2:0]  err
);

   // Bits are always packed from the truncated value, even when a range or
   // align error is flagged; B and J simply drop imm[0].
   always_comb begin
      instr_out = instr_in;
      err       = 3'b000;
      case (fmt)
         IMM_I: begin
            instr_out      = {imm[11:0], instr_in[19:0]};
            err[ERR_RANGE] = !fits_signed(imm, 12);
         end
         IMM_S: begin
            instr_out      = {imm[11:5], instr_in[24:12], imm[4:0], instr_in[6:0]};
            err[ERR_RANGE] = !fits_signed(imm, 12);
         end
         IMM_B: begin
            instr_out      = {imm[12], imm[10:5], instr_in[24:12],
                              imm[4:1], imm[11], instr_in[6:0]};
            err[ERR_RANGE] = !fits_signed(imm, 13);
            err[ERR_ALIGN] = imm[0];
         end
         IMM_J: begin
            instr_out      = {imm[20], imm[10:1], imm[11], imm[19:12], instr_in[11:0]};
            err[ERR_RANGE] = !fits_signed(imm, 21);
            err[ERR_ALIGN] = imm[0];
         end
         IMM_U: begin
            instr_out      = {imm[31:12], instr_in[11:0]};
            err[ERR_RANGE] = |imm[11:0];
         end
         default: begin
            // Illegal format: word passes through untouched, only fmt flagged.
            instr_out    = instr_in;
            err[ERR_FMT] = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_encoder.sv
// Pipelined RISC-V immediate encoder with a sticky, saturating error counter.
// Latency: 2 cycles (S1 input register + imm_pack, S2 output register); 1 item/cycle.
// Backpressure: valid/ready; in_ready = !S1.valid || S2 loads, outputs hold while stalled.
// Ports: in_* request (fmt/imm/instr/tag), out_* result (instr/err/tag),
//        err_clr / err_cnt for the count of erroring results delivered.
module imm_encoder
   import imm_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_fmt,
   input  logic [31:0]      in_imm,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic [2:0]       out_err,
   output logic [TAG_W-1:0] out_tag,
   input  logic             err_clr,
   output logic [15:0]      err_cnt
);

   // Stage 1: raw input registers.
   logic             s1_vld_q,   s1_vld_d;
   logic [2:0]       s1_fmt_q,   s1_fmt_d;
   logic [31:0]      s1_imm_q,   s1_imm_d;
   logic [31:0]      s1_instr_q, s1_instr_d;
   logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

   // Stage 2: packed result (output register).
   logic             s2_vld_q, s2_vld_d;
   enc_item_t        s2_q,     s2_d;

   logic [15:0]      err_cnt_q, err_cnt_d;

   logic             s1_load;
   logic             s2_load;
   logic             out_hs;
   logic             err_hs;
   logic [31:0]      pack_instr;
   logic [2:0]       pack_err;
   enc_item_t        s1_item;

   // A stage loads when empty or when its occupant leaves this cycle.
   assign s2_load  = s1_vld_q && (!s2_vld_q || out_ready);
   // Held low during reset so nothing is accepted into a stage being cleared.
   assign in_ready = !reset && (!s1_vld_q || s2_load);
   assign s1_load  = in_valid && in_ready;
   assign out_hs   = s2_vld_q && out_ready;
   assign err_hs   = out_hs && (s2_q.err != 3'b000);

   imm_pack u_pack (
      .fmt       (s1_fmt_q),
      .imm       (s1_imm_q),
      .instr_in  (s1_instr_q),
      .instr_out (pack_instr),
      .err       (pack_err)
   );

   always_comb begin
      s1_item       = '0;
      s1_item.instr = pack_instr;
      s1_item.err   = pack_err;
      s1_item.tag   = ENC_TAG_W'(s1_tag_q);
   end

   always_comb begin
      s1_vld_d   = s1_vld_q;
      s1_fmt_d   = s1_fmt_q;
      s1_imm_d   = s1_imm_q;
      s1_instr_d = s1_instr_q;
      s1_tag_d   = s1_tag_q;
      s2_vld_d   = s2_vld_q;
      s2_d       = s2_q;
      err_cnt_d  = err_cnt_q;

      if (s1_load) begin
         s1_vld_d   = 1'b1;
         s1_fmt_d   = in_fmt;
         s1_imm_d   = in_imm;
         s1_instr_d = in_instr;
         s1_tag_d   = in_tag;
      end else if (s2_load) begin
         s1_vld_d   = 1'b0;
      end

      // Data is only replaced on a load, so a stalled result never changes.
      if (s2_load) begin
         s2_vld_d = 1'b1;
         s2_d     = s1_item;
      end else if (out_hs) begin
         s2_vld_d = 1'b0;
      end

      // A clear that lands on an erroring handshake still counts that result.
      if (err_clr) begin
         err_cnt_d = err_hs ? 16'd1 : 16'd0;
      end else if (err_hs && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_vld_q   <= 1'b0;
         s1_fmt_q   <= 3'b000;
         s1_imm_q   <= 32'h0;
         s1_instr_q <= 32'h0;
         s1_tag_q   <= '0;
         s2_vld_q   <= 1'b0;
         s2_q       <= '0;
         err_cnt_q  <= 16'h0;
      end else begin
         s1_vld_q   <= s1_vld_d;
         s1_fmt_q   <= s1_fmt_d;
         s1_imm_q   <= s1_imm_d;
         s1_instr_q <= s1_instr_d;
         s1_tag_q   <= s1_tag_d;
         s2_vld_q   <= s2_vld_d;
         s2_q       <= s2_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign out_valid = s2_vld_q;
   assign out_instr = s2_q.instr;
   assign out_err   = s2_q.err;
   assign out_tag   = TAG_W'(s2_q.tag);
   assign err_cnt   = err_cnt_q;

endmodule
